// File: rtl/sdpram_rd_arb.sv
// Round-robin read-port arbiter for a single-clock simple dual-port RAM.
// Tags each accepted read and returns it one-hot to its owner after the RAM read latency.
module sdpram_rd_arb #(
  parameter int unsigned REQ_NUM     = 4,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned RAM_OUT_REG = 1
) (
  input  logic                          clk_sys,
  input  logic                          rst,
  input  logic                          arb_en,
  input  logic [REQ_NUM-1:0]            req_vld,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr,
  output logic [REQ_NUM-1:0]            req_rdy,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic                          ram_rdclocken,
  output logic [ADDR_WIDTH-1:0]         ram_rdaddress,
  input  logic [DATA_WIDTH-1:0]         ram_q,
  output logic [REQ_NUM-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [15:0]                   coll_cnt
);

  localparam int unsigned GNT_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int unsigned LAT   = 1 + RAM_OUT_REG;

  logic [GNT_W-1:0]      last_gnt_q, last_gnt_d;
  logic [ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;
  logic [15:0]           coll_cnt_q, coll_cnt_d;
  logic [REQ_NUM-1:0]    tag_q [LAT];

  logic [GNT_W-1:0]      cand_idx;
  logic                  cand_found;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic                  coll;
  logic                  grant;
  int unsigned           idx;

  // First valid requester searching upward from last_gnt+1, wrapping.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    idx        = 0;
    for (int unsigned k = 1; k <= REQ_NUM; k++) begin
      idx = (32'(last_gnt_q) + k) % REQ_NUM;
      if (!cand_found && req_vld[GNT_W'(idx)]) begin
        cand_found = 1'b1;
        cand_idx   = GNT_W'(idx);
      end
    end
  end

  // A same-cycle write to the candidate address stalls the read; the candidate keeps priority.
  always_comb begin
    cand_addr     = req_addr[cand_idx*ADDR_WIDTH +: ADDR_WIDTH];
    coll          = !rst && arb_en && cand_found && wr_en && (wr_addr == cand_addr);
    grant         = !rst && arb_en && cand_found && !coll;
    req_rdy       = grant ? (REQ_NUM'(1) << cand_idx) : '0;
    rdaddr_d      = grant ? cand_addr : rdaddr_q;
    ram_rdaddress = rdaddr_d;
    last_gnt_d    = grant ? cand_idx : last_gnt_q;
    coll_cnt_d    = coll_cnt_q;
    if (coll && (coll_cnt_q != 16'hFFFF)) begin
      coll_cnt_d = coll_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      last_gnt_q <= GNT_W'(REQ_NUM - 1);
      rdaddr_q   <= '0;
      coll_cnt_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      last_gnt_q <= last_gnt_d;
      rdaddr_q   <= rdaddr_d;
      coll_cnt_q <= coll_cnt_d;
      tag_q[0]   <= req_rdy;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rsp_vld       = tag_q[LAT-1];
  assign rsp_data      = ram_q;
  assign coll_cnt      = coll_cnt_q;
  assign ram_rdclocken = 1'b1;

endmodule

// File: tb/tb_sdpram_rd_arb.sv
// Directed bench for sdpram_rd_arb with a behavioural 2-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_sdpram_rd_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic            clk_sys = 1'b0;
  logic            rst;
  logic            arb_en;
  logic [N-1:0]    req_vld;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rdy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            ram_rdclocken;
  logic [AW-1:0]   ram_rdaddress;
  logic [DW-1:0]   ram_q;
  logic [N-1:0]    rsp_vld;
  logic [DW-1:0]   rsp_data;
  logic [15:0]     coll_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  sdpram_rd_arb #(.REQ_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_OUT_REG(1)) dut (
    .clk_sys(clk_sys), .rst(rst), .arb_en(arb_en), .req_vld(req_vld), .req_addr(req_addr),
    .req_rdy(req_rdy), .wr_en(wr_en), .wr_addr(wr_addr), .ram_rdclocken(ram_rdclocken),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .coll_cnt(coll_cnt)
  );

  // RAM model: registered address plus output register (read latency 2).
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_stage, q_reg;
  always @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_stage <= mem[ram_rdaddress];
    q_reg    <= rd_stage;
  end
  assign ram_q = q_reg;

  task automatic cyc_end();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_vld = '0; wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc_end();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arb_en = 1'b1; req_vld = '1; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cyc_end();
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b exp=0000", req_rdy); end
    total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL reset_rsp got=%b exp=0000", rsp_vld); end
    total++; if (coll_cnt !== 16'd0) begin bad++; $display("FAIL reset_coll got=%0d exp=0", coll_cnt); end
    total++; if (ram_rdaddress !== 10'd0) begin bad++; $display("FAIL reset_rdaddr got=%h exp=000", ram_rdaddress); end
    total++; if (ram_rdclocken !== 1'b1) begin bad++; $display("FAIL reset_clken got=%b exp=1", ram_rdclocken); end
    cyc_end();
    rst = 1'b0; req_vld = '0;
  endtask

  task automatic test_single();
    preload(10'h005, 8'hA5);
    req_vld = 4'b0100; set_addr(2, 10'h005);
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL single_rdy got=%b exp=0100", req_rdy); end
    total++; if (ram_rdaddress !== 10'h005) begin bad++; $display("FAIL single_addr got=%h exp=005", ram_rdaddress); end
    cyc_end();
    req_vld = '0;
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL single_early got=%b exp=0000", rsp_vld); end
    total++; if (ram_rdaddress !== 10'h005) begin bad++; $display("FAIL single_hold got=%h exp=005", ram_rdaddress); end
    cyc_end();
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0100) begin bad++; $display("FAIL single_rsp got=%b exp=0100", rsp_vld); end
    total++; if (rsp_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", rsp_data); end
    cyc_end();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy, exp_rsp;
    for (int i = 0; i < 4; i++) preload(AW'(10'h020 + i), DW'(8'h50 + i));
    rst = 1'b1;
    cyc_end();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, AW'(10'h020 + i));
    for (int k = 0; k < 10; k++) begin
      req_vld = (k < 8) ? 4'b1111 : 4'b0000;
      exp_rdy = (k < 8) ? N'(1 << (k % 4)) : '0;
      exp_rsp = (k >= 2) ? N'(1 << ((k - 2) % 4)) : '0;
      @(negedge clk_sys);
      total++; if (req_rdy !== exp_rdy) begin bad++; $display("FAIL rr_rdy cyc=%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
      total++; if (rsp_vld !== exp_rsp) begin bad++; $display("FAIL rr_rsp cyc=%0d got=%b exp=%b", k, rsp_vld, exp_rsp); end
      if (k >= 2) begin
        total++;
        if (rsp_data !== DW'(8'h50 + (k - 2) % 4)) begin
          bad++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", k, rsp_data, DW'(8'h50 + (k - 2) % 4));
        end
      end
      cyc_end();
    end
    req_vld = '0;
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL rr_tail got=%b exp=0000", rsp_vld); end
    cyc_end();
  endtask

  task automatic test_collision();
    preload(10'h010, 8'h00);
    req_vld = 4'b0010; set_addr(1, 10'h010);
    wr_en = 1'b1; wr_addr = 10'h010; wr_data = 8'h3C;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL coll_stall got=%b exp=0000", req_rdy); end
    total++; if (coll_cnt !== 16'd0) begin bad++; $display("FAIL coll_cnt0 got=%0d exp=0", coll_cnt); end
    cyc_end();
    wr_en = 1'b0;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL coll_retry got=%b exp=0010", req_rdy); end
    total++; if (coll_cnt !== 16'd1) begin bad++; $display("FAIL coll_cnt1 got=%0d exp=1", coll_cnt); end
    cyc_end();
    req_vld = '0;
    cyc_end();
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0010) begin bad++; $display("FAIL coll_rsp got=%b exp=0010", rsp_vld); end
    total++; if (rsp_data !== 8'h3C) begin bad++; $display("FAIL coll_data got=%h exp=3c", rsp_data); end
    cyc_end();
  endtask

  task automatic test_priority_hold();
    req_vld = 4'b0001; set_addr(0, 10'h000);
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL prio_g0 got=%b exp=0001", req_rdy); end
    cyc_end();
    req_vld = 4'b0110; set_addr(1, 10'h011); set_addr(2, 10'h012);
    wr_en = 1'b1; wr_addr = 10'h011; wr_data = 8'h77;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL prio_stall got=%b exp=0000", req_rdy); end
    cyc_end();
    wr_en = 1'b0;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL prio_hold got=%b exp=0010", req_rdy); end
    total++; if (rsp_vld !== 4'b0001) begin bad++; $display("FAIL prio_rsp0 got=%b exp=0001", rsp_vld); end
    total++; if (coll_cnt !== 16'd2) begin bad++; $display("FAIL prio_cnt got=%0d exp=2", coll_cnt); end
    cyc_end();
    req_vld = 4'b0100;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL prio_next got=%b exp=0100", req_rdy); end
    total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL prio_gap got=%b exp=0000", rsp_vld); end
    cyc_end();
    req_vld = '0;
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0010) begin bad++; $display("FAIL prio_rsp1 got=%b exp=0010", rsp_vld); end
    total++; if (rsp_data !== 8'h77) begin bad++; $display("FAIL prio_data got=%h exp=77", rsp_data); end
    cyc_end();
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0100) begin bad++; $display("FAIL prio_rsp2 got=%b exp=0100", rsp_vld); end
    cyc_end();
  endtask

  task automatic test_arb_en();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) set_addr(i, AW'(10'h020 + i));
    arb_en = 1'b1; req_vld = 4'b0011;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL en_g0 got=%b exp=0001", req_rdy); end
    cyc_end();
    req_vld = 4'b0010;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL en_g1 got=%b exp=0010", req_rdy); end
    cyc_end();
    arb_en = 1'b0; req_vld = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL en_off_rdy cyc=%0d got=%b exp=0000", k, req_rdy); end
      if (rsp_vld != '0) pulses++;
      if (k == 0) begin
        total++; if (rsp_vld !== 4'b0001 || rsp_data !== 8'h50) begin bad++; $display("FAIL en_rsp0 got=%b/%h exp=0001/50", rsp_vld, rsp_data); end
      end
      if (k == 1) begin
        total++; if (rsp_vld !== 4'b0010 || rsp_data !== 8'h51) begin bad++; $display("FAIL en_rsp1 got=%b/%h exp=0010/51", rsp_vld, rsp_data); end
      end
      cyc_end();
    end
    total++; if (pulses !== 2) begin bad++; $display("FAIL en_pulses got=%0d exp=2", pulses); end
    arb_en = 1'b1;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL en_resume got=%b exp=0100", req_rdy); end
    cyc_end();
    req_vld = '0;
    cyc_end();
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0100 || rsp_data !== 8'h52) begin bad++; $display("FAIL en_rsp2 got=%b/%h exp=0100/52", rsp_vld, rsp_data); end
    cyc_end();
  endtask

  task automatic test_reset_mid();
    req_vld = 4'b0001;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL rst_g got=%b exp=0001", req_rdy); end
    cyc_end();
    rst = 1'b1; req_vld = 4'b1111;
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL rst_gate got=%b exp=0000", req_rdy); end
    cyc_end();
    rst = 1'b0;
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL rst_discard got=%b exp=0000", rsp_vld); end
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL rst_first got=%b exp=0001", req_rdy); end
    cyc_end();
    @(negedge clk_sys);
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL rst_second got=%b exp=0010", req_rdy); end
    total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL rst_quiet got=%b exp=0000", rsp_vld); end
    cyc_end();
    req_vld = '0;
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0001 || rsp_data !== 8'h50) begin bad++; $display("FAIL rst_rsp0 got=%b/%h exp=0001/50", rsp_vld, rsp_data); end
    cyc_end();
    @(negedge clk_sys);
    total++; if (rsp_vld !== 4'b0010 || rsp_data !== 8'h51) begin bad++; $display("FAIL rst_rsp1 got=%b/%h exp=0010/51", rsp_vld, rsp_data); end
    cyc_end();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_priority_hold();
    test_arb_en();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
